fpga_robots_game_ticks: RTL and testbench
=========================================

FPGA_ROBOTS_GAME_TICKS -- requirements
Module: fpga_robots_game_ticks

Interface
REQ-001 Parameter NCHAN, default 4: number of independent timing channels; legal range 1..16.
REQ-002 Parameter ACC_W, default 19: phase accumulator width per channel; legal range 8..32.
REQ-003 Parameter STEP_INIT, default 929: step loaded into every channel at reset (115,200 baud at 65MHz).
REQ-004 Parameter DIV_N, default 6: tick8 pulses per slow pulse; legal range 2..16.
REQ-005 clk  input  1: the single clock, game logic clock domain; all logic on rising edge.
REQ-006 rst  input  1: reset, synchronous, active-high.
REQ-007 wr_en  input  1: step write strobe, one cycle.
REQ-008 wr_chan  input  4: channel index for the write.
REQ-009 wr_step  input  ACC_W: new step value.
REQ-010 sync  input  1: phase-align strobe for all channels.
REQ-011 tick  output  NCHAN: per-channel single-cycle pulse at step/2^ACC_W times clk rate.
REQ-012 tick8  output  NCHAN: per-channel single-cycle pulse at 8x the tick rate.
REQ-013 slow  output  NCHAN: per-channel single-cycle pulse once per DIV_N tick8 pulses.

Function
REQ-014 Each channel SHALL hold acc[ACC_W-1:0] and step[ACC_W-1:0]; each edge without rst/sync: acc <= (acc+step) mod 2^ACC_W.
REQ-015 tick[i] SHALL be registered, high for exactly the cycle after an edge on which acc+step carried out of bit ACC_W-1.
REQ-016 tick8[i] SHALL be registered, high for the cycle after an edge on which bit ACC_W-3 of acc+step differs from bit ACC_W-3 of acc.
REQ-017 A write with wr_step >= 2^(ACC_W-3) or wr_chan >= NCHAN SHALL be ignored, with no state change.
REQ-018 An accepted write SHALL update step on that edge; the first accumulation using the new step is on the following edge; acc is not altered by a write.
REQ-019 step = 0 SHALL stop the channel: acc holds, no tick/tick8/slow pulses.
REQ-020 sync high SHALL clear every acc and every divider count on that edge and force tick, tick8, slow low for the next cycle.
REQ-021 sync and an accepted wr_en on the same edge SHALL both take effect: acc cleared, step updated.
REQ-022 Channels SHALL be fully independent; simultaneous pulses on several channels are legal.

Reset
REQ-023 rst SHALL set every acc to 0, every step to STEP_INIT, every divider count to 0, and tick, tick8, slow to all-zero, on the same edge.
REQ-024 rst SHALL take priority over sync and wr_en; an in-progress period is discarded with no partial pulse.

Configuration
REQ-025 Macro FPGA_ROBOTS_GAME_TICKS_SLOW_EN defined: the per-channel divider and slow output SHALL be built per REQ-026.
REQ-026 Divider: cnt counts registered tick8 pulses; when tick8[i] and cnt = DIV_N-1, slow[i] pulses next cycle and cnt <= 0.
REQ-027 Macro undefined: divider logic SHALL be omitted and slow SHALL be constant zero; the port remains.

Structure
REQ-028 Shared package fpga_robots_game_pkg SHALL hold constants STEP_115200_65MHZ = 929, default ACC_W = 19, and default DIV_N = 6.
REQ-029 One sub-module fpga_robots_game_tick_chan SHALL implement a single channel, holding acc, step, divider and the three output registers.
REQ-030 The top SHALL instantiate NCHAN copies and decode wr_chan to per-channel write enables.

Verification
REQ-031 Default params, STEP_INIT=929, 65,000 cycles after reset -> each channel: tick count 115 or 116; tick8 count 920..924.
REQ-032 Write step=32768 to ch1 -> after sync: ch1 tick every 16 cycles exactly, tick8 every 2 cycles, slow every 12 cycles; ch0 unaffected.
REQ-033 Write step=65536 to ch0, and separately wr_chan=7 with NCHAN=4 -> both ignored; ch0 keeps its prior period.
REQ-034 Write step=0 to ch2 -> no ch2 pulses for 10,000 cycles; a later write of 929 resumes pulses.
REQ-035 Assert rst mid-period, and sync with a simultaneous write -> all outputs 0 next cycle; acc=0; step=STEP_INIT after rst, or the written value after sync+write.
REQ-036 Build without FPGA_ROBOTS_GAME_TICKS_SLOW_EN -> slow stuck at 0 across REQ-032 stimulus; tick and tick8 identical to the build with the macro.

Source files
------------

// File: rtl/fpga_robots_game_pkg.sv
// Shared constants and types for the robots game tick generators.
package fpga_robots_game_pkg;

  localparam int STEP_115200_65MHZ = 929;
  localparam int DEFAULT_ACC_W     = 19;
  localparam int DEFAULT_DIV_N     = 6;
  localparam int CNT_W             = 4;

  typedef logic [3:0] chan_idx_t;

endpackage

// File: rtl/fpga_robots_game_tick_chan.sv
// One timing channel: phase accumulator, tick/tick8 pulse registers and the slow divider
// (the divider exists only when FPGA_ROBOTS_GAME_TICKS_SLOW_EN is defined).
module fpga_robots_game_tick_chan
  import fpga_robots_game_pkg::*;
#(
  parameter int ACC_W     = DEFAULT_ACC_W,
  parameter int STEP_INIT = STEP_115200_65MHZ,
  parameter int DIV_N     = DEFAULT_DIV_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_step,
  input  logic             sync,
  output logic             tick,
  output logic             tick8,
  output logic             slow
);

  localparam logic [ACC_W-1:0] STEP_RST = ACC_W'(STEP_INIT);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] step_r;
  logic [ACC_W:0]   sum_s;
  logic             carry_s;
  logic             t8_flip_s;
  logic             tick_r;
  logic             tick8_r;

  // Next accumulator value plus the carry-out and eighth-period boundary crossing.
  always_comb begin
    sum_s     = {1'b0, acc_r} + {1'b0, step_r};
    carry_s   = sum_s[ACC_W];
    t8_flip_s = sum_s[ACC_W-3] ^ acc_r[ACC_W-3];
  end

  // Accumulator, step and pulse registers; a write never disturbs the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r   <= '0;
      step_r  <= STEP_RST;
      tick_r  <= 1'b0;
      tick8_r <= 1'b0;
    end else begin
      if (wr_en) begin
        step_r <= wr_step;
      end
      if (sync) begin
        acc_r   <= '0;
        tick_r  <= 1'b0;
        tick8_r <= 1'b0;
      end else begin
        acc_r   <= sum_s[ACC_W-1:0];
        tick_r  <= carry_s;
        tick8_r <= t8_flip_s;
      end
    end
  end

  assign tick  = tick_r;
  assign tick8 = tick8_r;

`ifdef FPGA_ROBOTS_GAME_TICKS_SLOW_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             slow_r;

  // Divider counts registered tick8 pulses and emits slow on the DIV_N-th.
  always_ff @(posedge clk) begin
    if (rst || sync) begin
      cnt_r  <= '0;
      slow_r <= 1'b0;
    end else if (tick8_r) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r  <= '0;
        slow_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + CNT_ONE;
        slow_r <= 1'b0;
      end
    end else begin
      slow_r <= 1'b0;
    end
  end

  assign slow = slow_r;
`else
  assign slow = 1'b0;
`endif

endmodule

// File: rtl/fpga_robots_game_ticks.sv
// NCHAN independent baud/game tick generators with a shared step-write port.
// Define FPGA_ROBOTS_GAME_TICKS_SLOW_EN to build the per-channel slow divider.
module fpga_robots_game_ticks
  import fpga_robots_game_pkg::*;
#(
  parameter int NCHAN     = 4,
  parameter int ACC_W     = DEFAULT_ACC_W,
  parameter int STEP_INIT = STEP_115200_65MHZ,
  parameter int DIV_N     = DEFAULT_DIV_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  chan_idx_t        wr_chan,
  input  logic [ACC_W-1:0] wr_step,
  input  logic             sync,
  output logic [NCHAN-1:0] tick,
  output logic [NCHAN-1:0] tick8,
  output logic [NCHAN-1:0] slow
);

  logic wr_ok_s;

  // Steps of 2^(ACC_W-3) or more would skip eighth-period boundaries, so they are refused.
  always_comb begin
    if (wr_en && (wr_step[ACC_W-1 -: 3] == 3'b000)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    logic chan_wr_s;

    // Out-of-range channel indices match no channel and are dropped here.
    assign chan_wr_s = wr_ok_s && (wr_chan == 4'(i));

    fpga_robots_game_tick_chan #(
      .ACC_W     (ACC_W),
      .STEP_INIT (STEP_INIT),
      .DIV_N     (DIV_N)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (chan_wr_s),
      .wr_step (wr_step),
      .sync    (sync),
      .tick    (tick[i]),
      .tick8   (tick8[i]),
      .slow    (slow[i])
    );
  end

endmodule

// File: tb/tb_fpga_robots_game_ticks.sv
// Scoreboard bench for fpga_robots_game_ticks: stimulus queues expected pulse edges,
// levels and count windows; a negedge monitor pops and compares them.
module tb_fpga_robots_game_ticks;

  localparam int NCH = 4;
  localparam int AW  = 19;
  localparam int SI  = 929;
  localparam int DN  = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [3:0]     wr_chan;
  logic [AW-1:0]  wr_step;
  logic           sync;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] tick8;
  logic [NCH-1:0] slow;

  fpga_robots_game_ticks #(
    .NCHAN(NCH), .ACC_W(AW), .STEP_INIT(SI), .DIV_N(DN)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_chan(wr_chan),
    .wr_step(wr_step), .sync(sync), .tick(tick), .tick8(tick8), .slow(slow)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int e;
    logic [NCH-1:0] t;
    logic [NCH-1:0] t8;
    logic [NCH-1:0] s;
  } lvl_t;

  typedef struct {
    int start;
    int stop;
    int kind;
    int ch;
    int lo;
    int hi;
    int base;
  } win_t;

  int ev_q [3][NCH][$];
  lvl_t lv_q[$];
  win_t win_q[$];
  int tot [3][NCH];
  logic [NCH-1:0] watch = '0;

  function automatic logic [NCH-1:0] pulses(input int k);
    case (k)
      0:       return tick;
      1:       return tick8;
      default: return slow;
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      0:       return "tick";
      1:       return "tick8";
      default: return "slow";
    endcase
  endfunction

  // Monitor: compares DUT outputs against the queued expectations once per cycle.
  always @(negedge clk) begin
    logic [NCH-1:0] v;
    lvl_t l;
    win_t w;
    while (lv_q.size() > 0 && lv_q[0].e <= edge_cnt) begin
      l = lv_q.pop_front();
      checks++;
      if (l.e != edge_cnt || tick !== l.t || tick8 !== l.t8 || slow !== l.s) begin
        errors++;
        $display("FAIL level@%0d: tick=%b tick8=%b slow=%b, required %b %b %b",
                 l.e, tick, tick8, slow, l.t, l.t8, l.s);
      end
    end
    for (int k = 0; k < 3; k++) begin
      v = pulses(k);
      for (int c = 0; c < NCH; c++) begin
        if (watch[c]) begin
          while (ev_q[k][c].size() > 0 && ev_q[k][c][0] < edge_cnt) begin
            checks++;
            errors++;
            $display("FAIL missed %s ch%0d: no pulse by edge %0d, required at edge %0d",
                     kname(k), c, edge_cnt, ev_q[k][c][0]);
            void'(ev_q[k][c].pop_front());
          end
          if (v[c]) begin
            checks++;
            if (ev_q[k][c].size() > 0 && ev_q[k][c][0] == edge_cnt) begin
              void'(ev_q[k][c].pop_front());
            end else begin
              errors++;
              $display("FAIL unexpected %s ch%0d: pulse at edge %0d, next required at %0d",
                       kname(k), c, edge_cnt,
                       (ev_q[k][c].size() > 0) ? ev_q[k][c][0] : -1);
            end
          end
        end
      end
    end
    for (int i = 0; i < win_q.size(); i++) begin
      if (win_q[i].start == edge_cnt) begin
        w = win_q[i];
        w.base = tot[w.kind][w.ch];
        win_q[i] = w;
      end
    end
    for (int k = 0; k < 3; k++) begin
      v = pulses(k);
      for (int c = 0; c < NCH; c++) begin
        if (v[c]) tot[k][c] = tot[k][c] + 1;
      end
    end
    for (int i = win_q.size() - 1; i >= 0; i--) begin
      if (win_q[i].stop == edge_cnt) begin
        int n;
        w = win_q[i];
        n = tot[w.kind][w.ch] - w.base;
        checks++;
        if (n < w.lo || n > w.hi) begin
          errors++;
          $display("FAIL count %s ch%0d edges %0d..%0d: got %0d, required %0d..%0d",
                   kname(w.kind), w.ch, w.start, w.stop, n, w.lo, w.hi);
        end
        win_q.delete(i);
      end
    end
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int e);
    while (edge_cnt < e) tick_clk();
  endtask

  task automatic push_zero(input int e);
    lvl_t l;
    l.e = e; l.t = '0; l.t8 = '0; l.s = '0;
    lv_q.push_back(l);
  endtask

  task automatic add_win(input int kind, input int ch, input int start, input int stop,
                         input int lo, input int hi);
    win_t w;
    w.start = start; w.stop = stop; w.kind = kind; w.ch = ch;
    w.lo = lo; w.hi = hi; w.base = 0;
    win_q.push_back(w);
  endtask

  // Expected pulse edges after acc was cleared at edge base: the j-th tick (tick8) lands on
  // the first k with k*step >= j*2^19 (j*2^16); slow follows every DN-th tick8 by one edge.
  task automatic push_pattern(input int ch, input int base, input int step, input int len);
    longint k;
    for (int j = 1; j < 100000; j++) begin
      k = (longint'(j) * 524288 + step - 1) / step;
      if (k >= len) break;
      ev_q[0][ch].push_back(base + int'(k));
    end
    for (int j = 1; j < 100000; j++) begin
      k = (longint'(j) * 65536 + step - 1) / step;
      if (k >= len) break;
      ev_q[1][ch].push_back(base + int'(k));
    end
`ifdef FPGA_ROBOTS_GAME_TICKS_SLOW_EN
    for (int m = 1; m < 100000; m++) begin
      k = (longint'(m * DN) * 65536 + step - 1) / step + 1;
      if (k >= len) break;
      ev_q[2][ch].push_back(base + int'(k));
    end
`endif
    watch[ch] = 1'b1;
  endtask

  task automatic stop_watch(input int ch);
    watch[ch] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ev_q[k][ch].size() != 0) begin
        errors++;
        $display("FAIL leftover %s ch%0d: %0d pulses never seen, required 0 pending",
                 kname(k), ch, ev_q[k][ch].size());
        ev_q[k][ch].delete();
      end
    end
  endtask

  task automatic do_write(input int ch, input int step);
    wr_en = 1'b1;
    wr_chan = ch[3:0];
    wr_step = step[AW-1:0];
    tick_clk();
    wr_en = 1'b0;
  endtask

  task automatic do_sync(output int s);
    sync = 1'b1;
    s = edge_cnt + 1;
    push_zero(s);
    tick_clk();
    sync = 1'b0;
  endtask

  int r_e, s_e, w_e;
  int slow_lo, slow_hi;

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_chan = 4'd0; wr_step = '0; sync = 1'b0;
`ifdef FPGA_ROBOTS_GAME_TICKS_SLOW_EN
    slow_lo = 152; slow_hi = 154;
`else
    slow_lo = 0; slow_hi = 0;
`endif
    push_zero(1);
    push_zero(2);
    tick_clk();
    tick_clk();
    rst = 1'b0;
    r_e = edge_cnt;

    // Long-run rate at the reset step, plus exact early pulse positions on ch0.
    for (int c = 0; c < NCH; c++) begin
      add_win(0, c, r_e + 1, r_e + 65000, 115, 116);
      add_win(1, c, r_e + 1, r_e + 65000, 920, 924);
      add_win(2, c, r_e + 1, r_e + 65000, slow_lo, slow_hi);
    end
    push_pattern(0, r_e, SI, 900);
    run_to(r_e + 900);
    stop_watch(0);
    run_to(r_e + 65001);

    // ch1 to 32768, then phase align: 16/2/12-cycle periods; ch0 keeps 929.
    do_write(1, 32768);
    do_sync(s_e);
    push_pattern(1, s_e, 32768, 100);
    push_pattern(0, s_e, SI, 100);
    run_to(s_e + 100);
    stop_watch(0);
    stop_watch(1);

    // Oversized step and out-of-range channel are both dropped.
    do_write(0, 65536);
    do_write(7, 32768);
    do_sync(s_e);
    push_pattern(0, s_e, SI, 900);
    push_pattern(1, s_e, 32768, 900);
    push_pattern(2, s_e, SI, 900);
    push_pattern(3, s_e, SI, 900);
    run_to(s_e + 900);
    for (int c = 0; c < NCH; c++) stop_watch(c);

    // Step 0 freezes ch2; restoring 929 brings it back.
    do_write(2, 0);
    w_e = edge_cnt;
    for (int k = 0; k < 3; k++) add_win(k, 2, w_e + 2, w_e + 10001, 0, 0);
    run_to(w_e + 10002);
    do_write(2, SI);
    do_sync(s_e);
    push_pattern(2, s_e, SI, 900);
    run_to(s_e + 900);
    stop_watch(2);

    // Reset mid-period wins over a simultaneous sync and write.
    run_to(edge_cnt + 300);
    rst = 1'b1; sync = 1'b1;
    wr_en = 1'b1; wr_chan = 4'd1; wr_step = 19'd32768;
    s_e = edge_cnt + 1;
    push_zero(s_e);
    tick_clk();
    rst = 1'b0; sync = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < NCH; c++) push_pattern(c, s_e, SI, 900);
    run_to(s_e + 900);
    for (int c = 0; c < NCH; c++) stop_watch(c);

    // Sync and an accepted write on the same edge both take effect.
    run_to(edge_cnt + 200);
    wr_en = 1'b1; wr_chan = 4'd3; wr_step = 19'd32768;
    do_sync(s_e);
    wr_en = 1'b0;
    push_pattern(3, s_e, 32768, 100);
    for (int c = 0; c < 3; c++) push_pattern(c, s_e, SI, 100);
    run_to(s_e + 100);
    for (int c = 0; c < NCH; c++) stop_watch(c);

    run_to(edge_cnt + 2);
    checks++;
    if (win_q.size() != 0 || lv_q.size() != 0) begin
      errors++;
      $display("FAIL pending: windows=%0d levels=%0d, required 0 0", win_q.size(), lv_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
